xps2_tx: RTL and testbench

//  PS/2 host-to-device transmitter: sends one command byte to the keyboard (e.g. 0xED set-LEDs, 0xFF reset).

---
 rtl/xps2_tx.sv | 182 ++++++++++++++++++
 tb/tb_xps2_tx.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/xps2_tx.sv
`default_nettype none
// ============================================================================
// Module   : xps2_tx
// Brief    : PS/2 host-to-device command transmitter with open-drain pad
//            controls and busy/done/nack/timeout status.
// Revision : 1.0
// ============================================================================
module xps2_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sel,
    input  logic       we,
    input  logic [7:0] data_in,
    output logic [3:0] data_out,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy
);

    localparam int c_inh_w = $clog2(INHIBIT_CYCLES + 1);
    localparam int c_to_w  = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [c_inh_w-1:0] c_inh_last = c_inh_w'(INHIBIT_CYCLES - 1);
    localparam logic [c_inh_w-1:0] c_inh_max  = c_inh_w'(INHIBIT_CYCLES);
    localparam logic [c_inh_w-1:0] c_inh_one  = c_inh_w'(1);
    localparam logic [c_to_w-1:0]  c_to_last  = c_to_w'(TIMEOUT_CYCLES - 1);
    localparam logic [c_to_w-1:0]  c_to_max   = c_to_w'(TIMEOUT_CYCLES);
    localparam logic [c_to_w-1:0]  c_to_one   = c_to_w'(1);

    localparam logic [2:0] c_st_idle      = 3'd0;
    localparam logic [2:0] c_st_inhibit   = 3'd1;
    localparam logic [2:0] c_st_rts       = 3'd2;
    localparam logic [2:0] c_st_tx        = 3'd3;
    localparam logic [2:0] c_st_ack       = 3'd4;
    localparam logic [2:0] c_st_wait_idle = 3'd5;

    logic [2:0]         r_state;
    logic [c_inh_w-1:0] r_inh_cnt;
    logic [c_to_w-1:0]  r_to_cnt;
    logic [3:0]         r_bit_cnt;
    logic [7:0]         r_shift;
    logic               r_parity;
    logic               r_busy;
    logic               r_done;
    logic               r_nack;
    logic               r_timeout;
    logic               r_clk_s1;
    logic               r_clk_s2;
    logic               r_clk_prev;
    logic               r_data_s1;
    logic               r_data_s2;

    logic [2:0] w_state_nxt;
    logic       w_fall;
    logic       w_wr;
    logic       w_watch;
    logic       w_line_idle;
    logic       w_to_hit;
    logic       w_clk_oe;
    logic       w_data_oe;

    assign w_fall      = r_clk_prev & ~r_clk_s2;
    assign w_wr        = sel & we & (r_state == c_st_idle);
    assign w_watch     = (r_state == c_st_tx) || (r_state == c_st_ack) ||
                         (r_state == c_st_wait_idle);
    assign w_line_idle = r_clk_s2 & r_data_s2;
    // A clean return to idle on the same cycle as expiry counts as success.
    assign w_to_hit    = w_watch & ~w_fall & (r_to_cnt == c_to_last) &
                         ~((r_state == c_st_wait_idle) & w_line_idle);

    always_comb begin
        w_state_nxt = r_state;
        w_clk_oe    = 1'b0;
        w_data_oe   = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (w_wr) w_state_nxt = c_st_inhibit;
            end
            c_st_inhibit: begin
                w_clk_oe = 1'b1;
                if (r_inh_cnt == c_inh_last) w_state_nxt = c_st_rts;
            end
            c_st_rts: begin
                w_clk_oe    = 1'b1;
                w_data_oe   = 1'b1;
                w_state_nxt = c_st_tx;
            end
            c_st_tx: begin
                // Shift register is pre-aligned so bit 0 is always the live bit.
                if (r_bit_cnt == 4'd0)      w_data_oe = 1'b1;
                else if (r_bit_cnt <= 4'd8) w_data_oe = ~r_shift[0];
                else if (r_bit_cnt == 4'd9) w_data_oe = ~r_parity;
                if (w_fall && (r_bit_cnt == 4'd9)) w_state_nxt = c_st_ack;
            end
            c_st_ack: begin
                if (w_fall) w_state_nxt = c_st_wait_idle;
            end
            c_st_wait_idle: begin
                if (w_line_idle) w_state_nxt = c_st_idle;
            end
            default: w_state_nxt = c_st_idle;
        endcase
        if (w_to_hit) w_state_nxt = c_st_idle;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_st_idle;
            r_inh_cnt  <= '0;
            r_to_cnt   <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_parity   <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_nack     <= 1'b0;
            r_timeout  <= 1'b0;
            r_clk_s1   <= 1'b1;
            r_clk_s2   <= 1'b1;
            r_clk_prev <= 1'b1;
            r_data_s1  <= 1'b1;
            r_data_s2  <= 1'b1;
        end else begin
            r_clk_s1   <= ps2_clk_in;
            r_clk_s2   <= r_clk_s1;
            r_clk_prev <= r_clk_s2;
            r_data_s1  <= ps2_data_in;
            r_data_s2  <= r_data_s1;
            r_state    <= w_state_nxt;

            if (r_state == c_st_inhibit) begin
                if (r_inh_cnt != c_inh_max) r_inh_cnt <= r_inh_cnt + c_inh_one;
            end else begin
                r_inh_cnt <= '0;
            end

            if (!w_watch || w_fall) begin
                r_to_cnt <= '0;
            end else if (r_to_cnt != c_to_max) begin
                r_to_cnt <= r_to_cnt + c_to_one;
            end

            if (r_state == c_st_tx) begin
                if (w_fall && (r_bit_cnt != 4'd10)) r_bit_cnt <= r_bit_cnt + 4'd1;
                if (w_fall && (r_bit_cnt >= 4'd1) && (r_bit_cnt <= 4'd7))
                    r_shift <= {1'b0, r_shift[7:1]};
            end else begin
                r_bit_cnt <= '0;
            end

            if (w_wr) begin
                r_shift   <= data_in;
                r_parity  <= ~^data_in;
                r_busy    <= 1'b1;
                r_done    <= 1'b0;
                r_nack    <= 1'b0;
                r_timeout <= 1'b0;
            end else if (w_to_hit) begin
                r_timeout <= 1'b1;
                r_done    <= 1'b0;
                r_busy    <= 1'b0;
            end else if ((r_state == c_st_ack) && w_fall) begin
                r_nack <= r_data_s2;
            end else if ((r_state == c_st_wait_idle) && w_line_idle) begin
                r_busy <= 1'b0;
                r_done <= 1'b1;
            end
        end
    end

    assign ps2_clk_oe  = w_clk_oe;
    assign ps2_data_oe = w_data_oe;
    assign data_out    = {r_timeout, r_nack, r_done, r_busy};
    assign busy        = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_xps2_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_xps2_tx
// Brief    : Directed bench for xps2_tx with an open-drain pad and keyboard model.
// Revision : 1.0
// ============================================================================
module tb_xps2_tx;

    logic       clk;
    logic       rst;
    logic       sel;
    logic       we;
    logic [7:0] data_in;
    logic [3:0] data_out;
    logic       ps2_clk_in;
    logic       ps2_data_in;
    logic       ps2_clk_oe;
    logic       ps2_data_oe;
    logic       busy;
    logic       dev_clk;
    logic       dev_data;

    int n_tests;
    int n_fail;

    xps2_tx #(
        .INHIBIT_CYCLES(10),
        .TIMEOUT_CYCLES(50)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sel        (sel),
        .we         (we),
        .data_in    (data_in),
        .data_out   (data_out),
        .ps2_clk_in (ps2_clk_in),
        .ps2_data_in(ps2_data_in),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe),
        .busy       (busy)
    );

    // Wired-AND bus: either side can pull low, pull-up otherwise.
    assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
    assign ps2_data_in = dev_data & ~ps2_data_oe;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [7:0] d);
        sel = 1'b1; we = 1'b1; data_in = d;
        tick(1);
        sel = 1'b0; we = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick(3);
        n_tests++;
        if (data_out !== 4'b0000) begin
            n_fail++; $display("FAIL reset_status: got %b, expected 0000", data_out);
        end
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_busy: got %b, expected 0", busy);
        end
        n_tests++;
        if ({ps2_clk_oe, ps2_data_oe} !== 2'b00) begin
            n_fail++; $display("FAIL reset_oe: got %b, expected 00", {ps2_clk_oe, ps2_data_oe});
        end
        rst = 1'b0;
        tick(2);
    endtask

    task automatic test_frame(input string name, input logic [7:0] d,
                              input logic [9:0] exp_bits, input bit ack,
                              input logic [3:0] exp_status, input bit mid_write,
                              input bit probe_idle);
        int cnt;
        logic [9:0] got;
        bus_write(d);
        cnt = 0;
        while (ps2_clk_oe && !ps2_data_oe && cnt < 1000) begin cnt++; tick(1); end
        n_tests++;
        if (cnt !== 10) begin
            n_fail++; $display("FAIL %s inhibit_len: got %0d, expected 10", name, cnt);
        end
        cnt = 0;
        while (ps2_clk_oe && ps2_data_oe && cnt < 1000) begin cnt++; tick(1); end
        n_tests++;
        if (cnt !== 1) begin
            n_fail++; $display("FAIL %s rts_len: got %0d, expected 1", name, cnt);
        end
        tick(5);
        got = '0;
        for (int i = 1; i <= 11; i++) begin
            dev_clk = 1'b0;
            tick(8);
            if (i <= 10) got[i-1] = ps2_data_in;
            if (mid_write && i == 3) begin
                sel = 1'b1; we = 1'b1; data_in = 8'hFF;
                tick(1);
                sel = 1'b0; we = 1'b0;
                tick(1);
            end else begin
                tick(2);
            end
            dev_clk = 1'b1;
            if (i == 10 && ack) dev_data = 1'b0;
            if (i == 11) dev_data = 1'b1;
            if (i < 11) tick(10);
        end
        n_tests++;
        if (got !== exp_bits) begin
            n_fail++; $display("FAIL %s line_bits: got %b, expected %b", name, got, exp_bits);
        end
        if (probe_idle) begin
            tick(2);
            sel = 1'b1; we = 1'b1; data_in = 8'h11;
            tick(1);
            sel = 1'b0; we = 1'b0;
            n_tests++;
            if (data_out !== 4'b0010) begin
                n_fail++; $display("FAIL %s write_at_idle: got %b, expected 0010", name, data_out);
            end
            bus_write(8'h11);
            n_tests++;
            if (data_out !== 4'b0001) begin
                n_fail++; $display("FAIL %s write_after_idle: got %b, expected 0001", name, data_out);
            end
            cnt = 0;
            while (busy && cnt < 300) begin cnt++; tick(1); end
            n_tests++;
            if (data_out !== 4'b1000) begin
                n_fail++; $display("FAIL %s second_timeout: got %b, expected 1000", name, data_out);
            end
        end else begin
            cnt = 0;
            while (busy && cnt < 300) begin cnt++; tick(1); end
            n_tests++;
            if (data_out !== exp_status) begin
                n_fail++; $display("FAIL %s status: got %b, expected %b", name, data_out, exp_status);
            end
        end
        tick(3);
    endtask

    task automatic test_timeout;
        int cnt;
        bus_write(8'h3C);
        n_tests++;
        if (data_out !== 4'b0001) begin
            n_fail++; $display("FAIL timeout_start: got %b, expected 0001", data_out);
        end
        cnt = 0;
        while (ps2_clk_oe && cnt < 1000) begin cnt++; tick(1); end
        cnt = 0;
        while (ps2_data_oe && !ps2_clk_oe && cnt < 1000) begin cnt++; tick(1); end
        n_tests++;
        if (cnt !== 50) begin
            n_fail++; $display("FAIL timeout_len: got %0d, expected 50", cnt);
        end
        n_tests++;
        if ({ps2_clk_oe, ps2_data_oe} !== 2'b00) begin
            n_fail++; $display("FAIL timeout_oe: got %b, expected 00", {ps2_clk_oe, ps2_data_oe});
        end
        n_tests++;
        if (data_out !== 4'b1000) begin
            n_fail++; $display("FAIL timeout_status: got %b, expected 1000", data_out);
        end
        tick(3);
    endtask

    task automatic test_reset_mid;
        int cnt;
        bus_write(8'h5A);
        cnt = 0;
        while (ps2_clk_oe && cnt < 1000) begin cnt++; tick(1); end
        tick(5);
        for (int i = 0; i < 4; i++) begin
            dev_clk = 1'b0; tick(10);
            dev_clk = 1'b1; tick(10);
        end
        n_tests++;
        if (data_out !== 4'b0001) begin
            n_fail++; $display("FAIL midrst_before: got %b, expected 0001", data_out);
        end
        rst = 1'b1;
        tick(1);
        n_tests++;
        if ({ps2_clk_oe, ps2_data_oe} !== 2'b00) begin
            n_fail++; $display("FAIL midrst_oe: got %b, expected 00", {ps2_clk_oe, ps2_data_oe});
        end
        n_tests++;
        if (data_out !== 4'b0000 || busy !== 1'b0) begin
            n_fail++; $display("FAIL midrst_status: got %b busy %b, expected 0000 busy 0", data_out, busy);
        end
        rst = 1'b0;
        tick(2);
        test_frame("after_rst", 8'h5A, 10'h35A, 1'b1, 4'b0010, 1'b0, 1'b0);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b1;
        sel     = 1'b0;
        we      = 1'b0;
        data_in = 8'h00;
        dev_clk = 1'b1;
        dev_data = 1'b1;
        test_reset;
        test_frame("ed_ack",    8'hED, 10'h3ED, 1'b1, 4'b0010, 1'b0, 1'b0);
        test_frame("zero_midwr", 8'h00, 10'h300, 1'b1, 4'b0010, 1'b1, 1'b0);
        test_frame("ff_nack",   8'hFF, 10'h3FF, 1'b0, 4'b0110, 1'b0, 1'b0);
        test_timeout;
        test_reset_mid;
        test_frame("idle_probe", 8'hA5, 10'h3A5, 1'b1, 4'b0010, 1'b0, 1'b1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
